ibex_mult_pext_seq: RTL and testbench
=====================================

// Module: ibex_mult_pext_seq
// PURPOSE
//  Multi-cycle sequencer for the Pext multiplier datapath. Consumes the per-op decode
//  (mult mode, cycle count, accum-sub, add mode) from the Pext mult decode helper.
//  Steps the multiplier through its partial-product slices and holds an intermediate
//  result register between slices. Raises valid when the final slice completes.
//  Sits between the mult decode helper and the multiplier/adder datapath in the EX stage.
// PARAMETERS
//  IMD_W      34  width of intermediate partial-result register (imd_val)
//  B2B_EN     1   1: new op may start in the cycle after valid_o; 0: one IDLE bubble forced
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      synchronous reset, active low
//  mult_en_i      in   1      op request; held high by EX until valid_o, drop = kill
//  cycle_count_i  in   2      00=1 cyc, 01=2 cyc, 11=3 cyc (from decode helper)
//  mult_mode_i    in   2      ibex_pkg_pext::mult_pext_mode_e (M8x8/M16x16/M32x16/M32x32)
//  accum_sub_i    in   2      [1]=sub in 32x32 path, [0]=sub in 32x16 path
//  add_mode_i     in   2      00 none, 01 sum1+sum2, 10 rd+sum, 11 rd+sum1+sum2
//  partial_i      in   IMD_W  datapath result of current slice
//  mult_state_o   out  2      slice select: 00 AL*BL, 01 AL*BH+AH*BL, 10 AH*BH
//  mult_mode_o    out  2      mode to datapath, stable for whole op
//  accum_sub_o    out  2      accum-sub to datapath, stable for whole op
//  add_mode_o     out  2      add mode to datapath, stable for whole op
//  imd_val_o      out  IMD_W  registered partial result of previous slice
//  imd_val_we_o   out  1      imd register written this cycle
//  busy_o         out  1      op in flight past its first cycle
//  valid_o        out  1      final slice this cycle; datapath result is valid
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): state IDLE, imd_val_o=0, latched decode=0.
//  Combinational outputs follow the reset-state encoding:
//    mult_state_o=00, busy_o=0, valid_o=0, imd_val_we_o=0.
//  Reset mid-op: op abandoned, no valid_o; the next op starts clean.
//  FSM states:
//    IDLE -- no op in flight
//    S1   -- second slice
//    S2   -- third slice
//    HOLD -- bubble, only reachable when B2B_EN=0
//  Decode is sampled in the first cycle of an op (IDLE & mult_en_i) into latches.
//    First cycle: mode/accum/add outputs pass inputs straight through.
//    S1/S2: outputs come from the latches. Input changes after the first cycle are ignored.
//  Effective count: cycle_count_i=10 (illegal) is treated as 01.
//  1-cycle op (00): IDLE&en -> valid_o=1 same cycle, mult_state_o=00, no imd write, stay IDLE.
//  2-cycle op (01): IDLE&en
//    -> mult_state_o=00, imd_val_we_o=1, imd<=partial_i, go S1.
//    S1 -> mult_state_o=01, valid_o=1, go IDLE.
//    Latency 2 cycles.
//  3-cycle op (11): IDLE&en
//    -> state 00, imd write, go S1.
//    S1 -> state 01, imd write, go S2.
//    S2 -> state 10, valid_o=1, go IDLE.
//    Latency 3 cycles.
//  busy_o=1 in S1 and S2.
//  valid_o is a single-cycle pulse. Never asserted while mult_en_i=0.
//  Kill: mult_en_i=0 in S1 or S2 -> no valid_o, imd not written, IDLE next cycle.
//  Back-to-back:
//    B2B_EN=1: IDLE after valid accepts a held mult_en_i the next cycle as a new op.
//    B2B_EN=0: after valid -> HOLD one cycle (ignore en), then IDLE.
//  imd register holds its value when imd_val_we_o=0. It is never cleared except by reset.
//  Width: partial_i is stored verbatim; no sign handling here.
// TESTING
//  1-cycle: en=1, cnt=00, mode=M16x16
//    -> valid_o=1 same cycle, state=00, busy_o=0, imd_val_we_o=0.
//  2-cycle: en=1, cnt=01, partial_i=34'h1_2345_6789
//    -> cyc0 we=1, state=00.
//    -> cyc1 imd_val_o=34'h1_2345_6789, state=01, valid_o=1.
//  3-cycle: cnt=11, mode=M32x32, add_mode=11.
//    Change mode_i to M8x8 in cycle 1.
//    -> states 00,01,10; valid_o only in cycle 2; mult_mode_o=M32x32 throughout.
//  Kill: 3-cycle op, drop en in S1
//    -> no valid_o, imd unchanged from S0 write, IDLE next cycle, new 1-cycle op valid.
//  Reset: rst_ni=0 in S2 -> next cycle all outputs at reset values, imd_val_o=0.
//  B2B: two 2-cycle ops with en held
//    B2B_EN=1 -> valid at cycles 1 and 3.
//    B2B_EN=0 -> valid at cycles 1 and 4.
//  Illegal cnt=10 -> behaves as 2-cycle op, valid in cycle 1.

Source files
------------

// File: rtl/ibex_mult_pext_seq.sv
// Multi-cycle sequencer for the Pext multiplier: walks the datapath through its
// partial-product slices, keeps the intermediate result, and flags the final slice.
module ibex_mult_pext_seq #(
    parameter int unsigned IMD_W  = 34,
    parameter bit          B2B_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mult_en_i,
    input  logic [1:0]       cycle_count_i,
    input  logic [1:0]       mult_mode_i,
    input  logic [1:0]       accum_sub_i,
    input  logic [1:0]       add_mode_i,
    input  logic [IMD_W-1:0] partial_i,
    output logic [1:0]       mult_state_o,
    output logic [1:0]       mult_mode_o,
    output logic [1:0]       accum_sub_o,
    output logic [1:0]       add_mode_o,
    output logic [IMD_W-1:0] imd_val_o,
    output logic             imd_val_we_o,
    output logic             busy_o,
    output logic             valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S2   = 2'b10,
        HOLD = 2'b11
    } seq_state_e;

    seq_state_e       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       accum_q, accum_d;
    logic [1:0]       add_q, add_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [IMD_W-1:0] imd_q, imd_d;
    logic [1:0]       cnt_eff;
    seq_state_e       after_valid;

    // The illegal count encoding 10 is folded onto the 2-cycle op.
    assign cnt_eff     = (cycle_count_i == 2'b10) ? 2'b01 : cycle_count_i;
    assign after_valid = B2B_EN ? IDLE : HOLD;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        accum_d      = accum_q;
        add_d        = add_q;
        cnt_d        = cnt_q;
        mult_state_o = 2'b00;
        mult_mode_o  = mode_q;
        accum_sub_o  = accum_q;
        add_mode_o   = add_q;
        imd_val_we_o = 1'b0;
        busy_o       = 1'b0;
        valid_o      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // First cycle of an op: decode goes straight to the datapath and is latched.
                mult_mode_o = mult_mode_i;
                accum_sub_o = accum_sub_i;
                add_mode_o  = add_mode_i;
                if (mult_en_i) begin
                    mode_d  = mult_mode_i;
                    accum_d = accum_sub_i;
                    add_d   = add_mode_i;
                    cnt_d   = cnt_eff;
                    if (cnt_eff == 2'b00) begin
                        valid_o = 1'b1;
                        state_d = after_valid;
                    end else begin
                        imd_val_we_o = 1'b1;
                        state_d      = S1;
                    end
                end
            end
            S1: begin
                mult_state_o = 2'b01;
                busy_o       = 1'b1;
                if (!mult_en_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 2'b01) begin
                    valid_o = 1'b1;
                    state_d = after_valid;
                end else begin
                    imd_val_we_o = 1'b1;
                    state_d      = S2;
                end
            end
            S2: begin
                mult_state_o = 2'b10;
                busy_o       = 1'b1;
                if (!mult_en_i) begin
                    state_d = IDLE;
                end else begin
                    valid_o = 1'b1;
                    state_d = after_valid;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        imd_d = imd_val_we_o ? partial_i : imd_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            accum_q <= 2'b00;
            add_q   <= 2'b00;
            cnt_q   <= 2'b00;
            imd_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            accum_q <= accum_d;
            add_q   <= add_d;
            cnt_q   <= cnt_d;
            imd_q   <= imd_d;
        end
    end

    assign imd_val_o = imd_q;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Directed bench for ibex_mult_pext_seq: one instance with back-to-back starts
// enabled, one with the forced idle bubble after each valid.
module tb_ibex_mult_pext_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [1:0]  cnt_i, mode_i, accum_i, add_i;
    logic [33:0] partial;

    logic [1:0]  state_a, mode_a, accum_a, add_a;
    logic [33:0] imd_a;
    logic        we_a, busy_a, valid_a;
    logic [1:0]  state_b, mode_b, accum_b, add_b;
    logic [33:0] imd_b;
    logic        we_b, busy_b, valid_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_mult_pext_seq #(.IMD_W(34), .B2B_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .mult_en_i(en_a), .cycle_count_i(cnt_i),
        .mult_mode_i(mode_i), .accum_sub_i(accum_i), .add_mode_i(add_i),
        .partial_i(partial), .mult_state_o(state_a), .mult_mode_o(mode_a),
        .accum_sub_o(accum_a), .add_mode_o(add_a), .imd_val_o(imd_a),
        .imd_val_we_o(we_a), .busy_o(busy_a), .valid_o(valid_a)
    );

    ibex_mult_pext_seq #(.IMD_W(34), .B2B_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .mult_en_i(en_b), .cycle_count_i(cnt_i),
        .mult_mode_i(mode_i), .accum_sub_i(accum_i), .add_mode_i(add_i),
        .partial_i(partial), .mult_state_o(state_b), .mult_mode_o(mode_b),
        .accum_sub_o(accum_b), .add_mode_o(add_b), .imd_val_o(imd_b),
        .imd_val_we_o(we_b), .busy_o(busy_b), .valid_o(valid_b)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] cnt, input logic [1:0] mode,
                                 input logic [1:0] accum, input logic [1:0] add,
                                 input logic [33:0] part);
        en_a    = en;
        cnt_i   = cnt;
        mode_i  = mode;
        accum_i = accum;
        add_i   = add;
        partial = part;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_b  = 1'b0;
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        next_cycle();
        next_cycle();
        #2;
        checkOutput("rst_state", 34'(state_a), 34'h0);
        checkOutput("rst_busy", 34'(busy_a), 34'h0);
        checkOutput("rst_valid", 34'(valid_a), 34'h0);
        checkOutput("rst_we", 34'(we_a), 34'h0);
        checkOutput("rst_imd", imd_a, 34'h0);
        rst_n = 1'b1;

        $display("[TB] 1-cycle op");
        next_cycle();
        applyStimulus(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 34'h0);
        checkOutput("c1_valid", 34'(valid_a), 34'h1);
        checkOutput("c1_state", 34'(state_a), 34'h0);
        checkOutput("c1_busy", 34'(busy_a), 34'h0);
        checkOutput("c1_we", 34'(we_a), 34'h0);
        checkOutput("c1_mode", 34'(mode_a), 34'h1);

        $display("[TB] 2-cycle op");
        next_cycle();
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 34'h1_2345_6789);
        checkOutput("c2_we0", 34'(we_a), 34'h1);
        checkOutput("c2_state0", 34'(state_a), 34'h0);
        checkOutput("c2_valid0", 34'(valid_a), 34'h0);
        next_cycle();
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("c2_imd1", imd_a, 34'h1_2345_6789);
        checkOutput("c2_state1", 34'(state_a), 34'h1);
        checkOutput("c2_valid1", 34'(valid_a), 34'h1);
        checkOutput("c2_busy1", 34'(busy_a), 34'h1);
        next_cycle();
        applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("c2_valid2", 34'(valid_a), 34'h0);
        checkOutput("c2_busy2", 34'(busy_a), 34'h0);

        $display("[TB] 3-cycle op with decode change");
        next_cycle();
        applyStimulus(1'b1, 2'b11, 2'b11, 2'b10, 2'b11, 34'h0_0000_00AA);
        checkOutput("c3_state0", 34'(state_a), 34'h0);
        checkOutput("c3_we0", 34'(we_a), 34'h1);
        checkOutput("c3_valid0", 34'(valid_a), 34'h0);
        checkOutput("c3_mode0", 34'(mode_a), 34'h3);
        next_cycle();
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 34'h2_0000_0055);
        checkOutput("c3_state1", 34'(state_a), 34'h1);
        checkOutput("c3_valid1", 34'(valid_a), 34'h0);
        checkOutput("c3_we1", 34'(we_a), 34'h1);
        checkOutput("c3_mode1", 34'(mode_a), 34'h3);
        checkOutput("c3_imd1", imd_a, 34'h0_0000_00AA);
        next_cycle();
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("c3_state2", 34'(state_a), 34'h2);
        checkOutput("c3_valid2", 34'(valid_a), 34'h1);
        checkOutput("c3_mode2", 34'(mode_a), 34'h3);
        checkOutput("c3_add2", 34'(add_a), 34'h3);
        checkOutput("c3_accum2", 34'(accum_a), 34'h2);
        checkOutput("c3_imd2", imd_a, 34'h2_0000_0055);
        next_cycle();
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("c3_valid3", 34'(valid_a), 34'h0);

        $display("[TB] kill in S1");
        next_cycle();
        applyStimulus(1'b1, 2'b11, 2'b10, 2'b01, 2'b01, 34'h3_0000_0001);
        checkOutput("k_we0", 34'(we_a), 34'h1);
        next_cycle();
        applyStimulus(1'b0, 2'b11, 2'b10, 2'b01, 2'b01, 34'h0_0000_0005);
        checkOutput("k_state1", 34'(state_a), 34'h1);
        checkOutput("k_valid1", 34'(valid_a), 34'h0);
        checkOutput("k_we1", 34'(we_a), 34'h0);
        next_cycle();
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("k_busy2", 34'(busy_a), 34'h0);
        checkOutput("k_imd2", imd_a, 34'h3_0000_0001);
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("k_new_valid", 34'(valid_a), 34'h1);

        $display("[TB] reset in S2");
        next_cycle();
        applyStimulus(1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 34'h0_0000_0007);
        next_cycle();
        applyStimulus(1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 34'h0_0000_0008);
        next_cycle();
        checkOutput("r_state_s2", 34'(state_a), 34'h2);
        rst_n = 1'b0;
        next_cycle();
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("r_state", 34'(state_a), 34'h0);
        checkOutput("r_busy", 34'(busy_a), 34'h0);
        checkOutput("r_valid", 34'(valid_a), 34'h0);
        checkOutput("r_we", 34'(we_a), 34'h0);
        checkOutput("r_imd", imd_a, 34'h0);
        rst_n = 1'b1;

        $display("[TB] illegal count 10");
        next_cycle();
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 34'h0_0000_0009);
        checkOutput("i_we0", 34'(we_a), 34'h1);
        checkOutput("i_valid0", 34'(valid_a), 34'h0);
        next_cycle();
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 34'h0);
        checkOutput("i_valid1", 34'(valid_a), 34'h1);
        checkOutput("i_state1", 34'(state_a), 34'h1);
        checkOutput("i_imd1", imd_a, 34'h0_0000_0009);
        next_cycle();
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);

        $display("[TB] back-to-back 2-cycle ops");
        next_cycle();
        en_b = 1'b1;
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 34'h0_0000_0011);
        checkOutput("b2b_a_v0", 34'(valid_a), 34'h0);
        checkOutput("b2b_b_v0", 34'(valid_b), 34'h0);
        next_cycle();
        #2;
        checkOutput("b2b_a_v1", 34'(valid_a), 34'h1);
        checkOutput("b2b_b_v1", 34'(valid_b), 34'h1);
        next_cycle();
        #2;
        checkOutput("b2b_a_v2", 34'(valid_a), 34'h0);
        checkOutput("b2b_a_we2", 34'(we_a), 34'h1);
        checkOutput("b2b_b_v2", 34'(valid_b), 34'h0);
        checkOutput("b2b_b_we2", 34'(we_b), 34'h0);
        checkOutput("b2b_b_busy2", 34'(busy_b), 34'h0);
        next_cycle();
        #2;
        checkOutput("b2b_a_v3", 34'(valid_a), 34'h1);
        checkOutput("b2b_b_v3", 34'(valid_b), 34'h0);
        checkOutput("b2b_b_we3", 34'(we_b), 34'h1);
        next_cycle();
        #2;
        checkOutput("b2b_b_v4", 34'(valid_b), 34'h1);
        checkOutput("b2b_b_state4", 34'(state_b), 34'h1);
        next_cycle();
        en_b = 1'b0;
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 34'h0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
